// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 definitions: message type codes, wire type characters,
// per-type message lengths, header offsets and the structured message payload.
package itch_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [3:0] {
    MSG_NONE     = 4'd0,
    MSG_ADD      = 4'd1,
    MSG_CANCEL   = 4'd2,
    MSG_DELETE   = 4'd3,
    MSG_REPLACE  = 4'd4,
    MSG_EXECUTED = 4'd5,
    MSG_TRADE    = 4'd6
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } enc_state_e;

  localparam logic [7:0] CHAR_ADD      = 8'h41;
  localparam logic [7:0] CHAR_CANCEL   = 8'h58;
  localparam logic [7:0] CHAR_DELETE   = 8'h44;
  localparam logic [7:0] CHAR_REPLACE  = 8'h55;
  localparam logic [7:0] CHAR_EXECUTED = 8'h45;
  localparam logic [7:0] CHAR_TRADE    = 8'h50;

  localparam logic [CNT_W-1:0] LEN_ADD      = 6'd36;
  localparam logic [CNT_W-1:0] LEN_CANCEL   = 6'd23;
  localparam logic [CNT_W-1:0] LEN_DELETE   = 6'd19;
  localparam logic [CNT_W-1:0] LEN_REPLACE  = 6'd35;
  localparam logic [CNT_W-1:0] LEN_EXECUTED = 6'd31;
  localparam logic [CNT_W-1:0] LEN_TRADE    = 6'd44;

  localparam logic [CNT_W-1:0] OFF_TYPE     = 6'd0;
  localparam logic [CNT_W-1:0] OFF_LOCATE   = 6'd1;
  localparam logic [CNT_W-1:0] OFF_TRACKING = 6'd3;
  localparam logic [CNT_W-1:0] OFF_TS       = 6'd5;
  localparam logic [CNT_W-1:0] OFF_REF      = 6'd11;
  localparam logic [CNT_W-1:0] OFF_BODY     = 6'd19;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_num;
    logic [47:0] timestamp;
    logic [63:0] order_ref;
    logic [63:0] new_order_ref;
    logic [7:0]  side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
    logic [63:0] match_num;
  } itch_msg_t;

  function automatic logic is_supported(input logic [3:0] t);
    return (t >= MSG_ADD) && (t <= MSG_TRADE);
  endfunction

  function automatic logic [CNT_W-1:0] msg_len(input logic [3:0] t);
    case (t)
      MSG_ADD:      return LEN_ADD;
      MSG_CANCEL:   return LEN_CANCEL;
      MSG_DELETE:   return LEN_DELETE;
      MSG_REPLACE:  return LEN_REPLACE;
      MSG_EXECUTED: return LEN_EXECUTED;
      MSG_TRADE:    return LEN_TRADE;
      default:      return 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] type_char(input logic [3:0] t);
    case (t)
      MSG_ADD:      return CHAR_ADD;
      MSG_CANCEL:   return CHAR_CANCEL;
      MSG_DELETE:   return CHAR_DELETE;
      MSG_REPLACE:  return CHAR_REPLACE;
      MSG_EXECUTED: return CHAR_EXECUTED;
      MSG_TRADE:    return CHAR_TRADE;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/itch_msg_encoder_if.sv
// Message-in / byte-stream-out bundle between a message source and the encoder.
interface itch_msg_encoder_if;
  import itch_pkg::*;

  logic       msg_valid;
  logic       msg_ready;
  itch_msg_t  msg;
  logic [7:0] byte_out;
  logic       valid_out;
  logic       msg_done;
  logic       err_unknown;

  modport master (
    output msg_valid, msg,
    input  msg_ready, byte_out, valid_out, msg_done, err_unknown
  );

  modport slave (
    input  msg_valid, msg,
    output msg_ready, byte_out, valid_out, msg_done, err_unknown
  );
endinterface

// File: rtl/itch_byte_mux.sv
// Combinational lookup of the wire byte at a given offset of a structured
// message; multi-byte fields go out most-significant byte first.
module itch_byte_mux
  import itch_pkg::*;
(
  input  itch_msg_t        i_msg,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [7:0]       o_byte_c
);

  function automatic logic [7:0] be_byte(input logic [63:0] v, input int nbytes,
                                         input logic [CNT_W-1:0] k);
    int sh;
    sh = 8 * (nbytes - 1 - int'(k));
    return 8'(v >> sh);
  endfunction

  logic [CNT_W-1:0] w_rel;

  always_comb begin
    w_rel    = i_cnt - OFF_BODY;
    o_byte_c = 8'h00;
    if (i_cnt == OFF_TYPE)
      o_byte_c = type_char(i_msg.msg_type);
    else if (i_cnt < OFF_TRACKING)
      o_byte_c = be_byte(64'(i_msg.stock_locate), 2, i_cnt - OFF_LOCATE);
    else if (i_cnt < OFF_TS)
      o_byte_c = be_byte(64'(i_msg.tracking_num), 2, i_cnt - OFF_TRACKING);
    else if (i_cnt < OFF_REF)
      o_byte_c = be_byte(64'(i_msg.timestamp), 6, i_cnt - OFF_TS);
    else if (i_cnt < OFF_BODY)
      o_byte_c = be_byte(i_msg.order_ref, 8, i_cnt - OFF_REF);
    else begin
      // Body layout depends on the type; Trade extends the Add layout with match_num.
      case (i_msg.msg_type)
        MSG_ADD, MSG_TRADE: begin
          if (w_rel == 6'd0)      o_byte_c = i_msg.side;
          else if (w_rel < 6'd5)  o_byte_c = be_byte(64'(i_msg.shares), 4, w_rel - 6'd1);
          else if (w_rel < 6'd13) o_byte_c = be_byte(i_msg.stock, 8, w_rel - 6'd5);
          else if (w_rel < 6'd17) o_byte_c = be_byte(64'(i_msg.price), 4, w_rel - 6'd13);
          else if (i_msg.msg_type == MSG_TRADE && w_rel < 6'd25)
            o_byte_c = be_byte(i_msg.match_num, 8, w_rel - 6'd17);
        end
        MSG_CANCEL: begin
          if (w_rel < 6'd4) o_byte_c = be_byte(64'(i_msg.shares), 4, w_rel);
        end
        MSG_REPLACE: begin
          if (w_rel < 6'd8)       o_byte_c = be_byte(i_msg.new_order_ref, 8, w_rel);
          else if (w_rel < 6'd12) o_byte_c = be_byte(64'(i_msg.shares), 4, w_rel - 6'd8);
          else if (w_rel < 6'd16) o_byte_c = be_byte(64'(i_msg.price), 4, w_rel - 6'd12);
        end
        MSG_EXECUTED: begin
          if (w_rel < 6'd4)       o_byte_c = be_byte(64'(i_msg.shares), 4, w_rel);
          else if (w_rel < 6'd12) o_byte_c = be_byte(i_msg.match_num, 8, w_rel - 6'd4);
        end
        default: o_byte_c = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/itch_msg_encoder.sv
// Serializes one structured ITCH order message per handshake into a registered
// big-endian byte stream, with an optional idle gap between messages.
module itch_msg_encoder
  import itch_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
)
(
  input  logic              clk,
  input  logic              rst,
  itch_msg_encoder_if.slave bus
);

  // The idle IDLE state after GAP supplies the final gap cycle, so GAP itself is one short.
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 2);

  enc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_gap, w_gap_nxt;
  itch_msg_t        r_msg, w_src;
  logic             r_ready, r_valid, r_done, r_err;
  logic [7:0]       r_byte, w_byte;
  logic             w_accept, w_last;
  logic             w_valid_nxt, w_done_nxt, w_err_nxt, w_ready_nxt;
  logic [CNT_W-1:0] w_len, w_cur_len;

  assign w_accept  = bus.msg_valid && r_ready;
  assign w_src     = w_accept ? bus.msg : r_msg;
  assign w_len     = msg_len(w_src.msg_type);
  assign w_cur_len = msg_len(r_msg.msg_type);
  assign w_last    = (r_state == ST_SEND) && (r_cnt == w_cur_len - 6'd1);

  // Byte lookup runs on next-cycle state so the output can be registered.
  itch_byte_mux u_byte_mux (
    .i_msg    (w_src),
    .i_cnt    (w_cnt_nxt),
    .o_byte_c (w_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_SEND: begin
        if (w_last) begin
          if (IDLE_GAP > 1) begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + 6'd1;
          w_valid_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == 4'd0) w_state_nxt = ST_IDLE;
        else               w_gap_nxt   = r_gap - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A handshake can only land in IDLE or the last SEND cycle, so it overrides.
    if (w_accept) begin
      if (is_supported(bus.msg.msg_type)) begin
        w_state_nxt = ST_SEND;
        w_cnt_nxt   = 6'd0;
        w_valid_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = 1'b1;
      end
    end
    w_done_nxt  = w_valid_nxt && (w_cnt_nxt == w_len - 6'd1);
    w_ready_nxt = (w_state_nxt == ST_IDLE) || ((IDLE_GAP == 0) && w_done_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_gap   <= '0;
      r_msg   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_byte  <= 8'h00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      if (w_accept) r_msg <= bus.msg;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_byte  <= w_valid_nxt ? w_byte : 8'h00;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.msg_ready   = r_ready;
  assign bus.byte_out    = r_byte;
  assign bus.valid_out   = r_valid;
  assign bus.msg_done    = r_done;
  assign bus.err_unknown = r_err;

endmodule

// File: tb/tb_itch_msg_encoder.sv
// Bench for itch_msg_encoder: a gap-0 and a gap-3 instance checked cycle by cycle
// against a byte-layout reference model built from the ITCH message definitions.
module tb_itch_msg_encoder;
  import itch_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  itch_msg_encoder_if if0 ();
  itch_msg_encoder_if if3 ();

  itch_msg_encoder #(.IDLE_GAP(0)) dut0 (.clk(clk), .rst(rst_n), .bus(if0));
  itch_msg_encoder #(.IDLE_GAP(3)) dut3 (.clk(clk), .rst(rst_n), .bus(if3));

  int        sel = 0;
  logic      drv_valid = 1'b0;
  itch_msg_t drv_msg = '0;
  itch_msg_t pend[$];

  assign if0.msg_valid = drv_valid && (sel == 0);
  assign if3.msg_valid = drv_valid && (sel == 1);
  assign if0.msg = drv_msg;
  assign if3.msg = drv_msg;

  logic       obs_valid, obs_done, obs_err, obs_ready;
  logic [7:0] obs_byte;
  assign obs_valid = (sel == 1) ? if3.valid_out   : if0.valid_out;
  assign obs_done  = (sel == 1) ? if3.msg_done    : if0.msg_done;
  assign obs_err   = (sel == 1) ? if3.err_unknown : if0.err_unknown;
  assign obs_ready = (sel == 1) ? if3.msg_ready   : if0.msg_ready;
  assign obs_byte  = (sel == 1) ? if3.byte_out    : if0.byte_out;

  int n_vec = 0;
  int n_err = 0;

  logic       cap_v[$], cap_d[$], cap_e[$], cap_r[$];
  logic [7:0] cap_b[$];

  localparam int NEXP = 1024;
  logic       exp_v[NEXP], exp_d[NEXP], exp_e[NEXP], exp_r[NEXP];
  logic [7:0] exp_b[NEXP];
  bq_t        ref_q;

  // ---------------- reference model ----------------
  function automatic void emit(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) ref_q.push_back(v[8*i +: 8]);
  endfunction

  function automatic void ref_build(input itch_msg_t m);
    ref_q.delete();
    case (m.msg_type)
      4'd1: emit(64'h41, 1);
      4'd2: emit(64'h58, 1);
      4'd3: emit(64'h44, 1);
      4'd4: emit(64'h55, 1);
      4'd5: emit(64'h45, 1);
      4'd6: emit(64'h50, 1);
      default: return;
    endcase
    emit(64'(m.stock_locate), 2);
    emit(64'(m.tracking_num), 2);
    emit(64'(m.timestamp), 6);
    emit(m.order_ref, 8);
    case (m.msg_type)
      4'd1, 4'd6: begin
        emit(64'(m.side), 1); emit(64'(m.shares), 4);
        emit(m.stock, 8);     emit(64'(m.price), 4);
        if (m.msg_type == 4'd6) emit(m.match_num, 8);
      end
      4'd2: emit(64'(m.shares), 4);
      4'd4: begin
        emit(m.new_order_ref, 8); emit(64'(m.shares), 4); emit(64'(m.price), 4);
      end
      4'd5: begin emit(64'(m.shares), 4); emit(m.match_num, 8); end
      default: ;
    endcase
  endfunction

  function automatic void clear_exp();
    for (int i = 0; i < NEXP; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_e[i] = 1'b0; exp_r[i] = 1'b1; exp_b[i] = 8'h00;
    end
  endfunction

  // Expected outputs for a message accepted at the edge closing cycle start;
  // returns the cycle in which the encoder will take the next message.
  function automatic int place(input int start, input itch_msg_t m, input int gap);
    int len;
    ref_build(m);
    len = ref_q.size();
    if (len == 0) begin
      exp_e[start + 1] = 1'b1;
      return start + 1;
    end
    for (int i = 0; i < len; i++) begin
      exp_v[start + 1 + i] = 1'b1;
      exp_b[start + 1 + i] = ref_q[i];
    end
    exp_d[start + len] = 1'b1;
    for (int c = start + 1; c <= start + len + gap - 1; c++) exp_r[c] = 1'b0;
    return start + len + gap;
  endfunction

  function automatic itch_msg_t rand_msg(input logic [3:0] t);
    itch_msg_t m;
    m.msg_type      = t;
    m.stock_locate  = 16'($urandom);
    m.tracking_num  = 16'($urandom);
    m.timestamp     = {16'($urandom), $urandom};
    m.order_ref     = {$urandom, $urandom};
    m.new_order_ref = {$urandom, $urandom};
    m.side          = 8'($urandom);
    m.shares        = $urandom;
    m.stock         = {$urandom, $urandom};
    m.price         = $urandom;
    m.match_num     = {$urandom, $urandom};
    return m;
  endfunction

  function automatic logic [3:0] rand_type();
    if ($urandom_range(0, 5) == 0)
      return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(7, 15));
    return 4'($urandom_range(1, 6));
  endfunction

  // ---------------- driver / capture ----------------
  task automatic select(input int s);
    sel = s;
    #1;
  endtask

  task automatic run(input int n);
    cap_v.delete(); cap_d.delete(); cap_e.delete(); cap_r.delete(); cap_b.delete();
    for (int i = 0; i < n; i++) begin
      logic hs;
      if (!drv_valid && pend.size() > 0) begin
        drv_msg   = pend.pop_front();
        drv_valid = 1'b1;
      end
      cap_v.push_back(obs_valid); cap_b.push_back(obs_byte); cap_d.push_back(obs_done);
      cap_e.push_back(obs_err);   cap_r.push_back(obs_ready);
      hs = drv_valid && obs_ready;
      @(posedge clk); #1;
      if (hs) begin
        drv_valid = 1'b0;
        drv_msg   = rand_msg(4'($urandom_range(0, 15)));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      select(s);
      n_vec++;
      if ({obs_valid, obs_byte, obs_done, obs_err, obs_ready} !== 12'h0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d got v=%b b=%h d=%b e=%b r=%b want all 0",
                 s, obs_valid, obs_byte, obs_done, obs_err, obs_ready);
      end
    end
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      select(s);
      n_vec++;
      if (obs_ready !== 1'b0) begin
        n_err++; $display("FAIL ready_before_edge dut%0d got %b want 0", s, obs_ready);
      end
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      select(s);
      n_vec++;
      if (obs_ready !== 1'b1) begin
        n_err++; $display("FAIL ready_after_edge dut%0d got %b want 1", s, obs_ready);
      end
    end
  endtask

  task automatic test_delete();
    itch_msg_t  m;
    int         h;
    logic [7:0] kb[8];
    int         kc[8];
    m = '0;
    m.msg_type = 4'd3; m.stock_locate = 16'd1; m.tracking_num = 16'd2;
    m.timestamp = 48'h5; m.order_ref = 64'h1234;
    select(0);
    clear_exp();
    pend.push_back(m);
    h = place(0, m, 0);
    run(h + 3);
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL delete cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
    end
    kc = '{1, 2, 3, 4, 5, 18, 19, 20};
    kb = '{8'h44, 8'h00, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'h00};
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (cap_b[kc[i]] !== kb[i]) begin
        n_err++; $display("FAIL delete_byte cyc=%0d got %h want %h", kc[i], cap_b[kc[i]], kb[i]);
      end
    end
    n_vec++;
    if (cap_d[19] !== 1'b1 || cap_v[20] !== 1'b0) begin
      n_err++; $display("FAIL delete_end got done19=%b valid20=%b want 1 0", cap_d[19], cap_v[20]);
    end
  endtask

  task automatic test_add();
    itch_msg_t  m;
    int         h;
    logic [7:0] kb[9];
    int         kc[9];
    m = rand_msg(4'd1);
    m.shares = 32'd100; m.price = 32'h0001_86A0; m.side = 8'h42; m.stock = 64'h4141_504C_2020_2020;
    select(1);
    clear_exp();
    pend.push_back(m);
    h = place(0, m, 3);
    run(h + 2);
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL add cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
    end
    kc = '{20, 21, 22, 23, 24, 33, 34, 35, 36};
    kb = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h01, 8'h86, 8'hA0};
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (cap_b[kc[i]] !== kb[i]) begin
        n_err++; $display("FAIL add_byte cyc=%0d got %h want %h", kc[i], cap_b[kc[i]], kb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    itch_msg_t mc, mr;
    int        h, nv, nd;
    mc = rand_msg(4'd2);
    mr = rand_msg(4'd4);
    select(0);
    clear_exp();
    pend.push_back(mc);
    pend.push_back(mr);
    h = place(0, mc, 0);
    h = place(h, mr, 0);
    run(h + 3);
    nv = 0; nd = 0;
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL b2b cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
      if (i >= 1 && i <= 58 && cap_v[i] === 1'b1) nv++;
      if (cap_d[i] === 1'b1) nd++;
    end
    n_vec++;
    if (nv != 58 || nd != 2 || cap_b[24] !== 8'h55) begin
      n_err++;
      $display("FAIL b2b_shape got valid_run=%0d dones=%0d b24=%h want 58 2 55", nv, nd, cap_b[24]);
    end
  endtask

  task automatic test_gap();
    itch_msg_t m1, m2;
    int        h, nz;
    m1 = rand_msg(4'd5);
    m2 = rand_msg(4'd5);
    select(1);
    clear_exp();
    pend.push_back(m1);
    pend.push_back(m2);
    h = place(0, m1, 3);
    h = place(h, m2, 3);
    run(h + 2);
    nz = 0;
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL gap cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
      if (i > 31 && i < 35 && cap_v[i] === 1'b0) nz++;
    end
    n_vec++;
    if (nz != 3 || cap_v[31] !== 1'b1 || cap_v[35] !== 1'b1) begin
      n_err++;
      $display("FAIL gap_len got idle=%0d v31=%b v35=%b want 3 1 1", nz, cap_v[31], cap_v[35]);
    end
  endtask

  task automatic test_unknown();
    itch_msg_t mu, mt;
    int        h, ne;
    mu = rand_msg(4'd9);
    mt = rand_msg(4'd6);
    select(0);
    clear_exp();
    pend.push_back(mu);
    pend.push_back(mt);
    h = place(0, mu, 0);
    h = place(h, mt, 0);
    run(h + 3);
    ne = 0;
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL unknown cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
      if (cap_e[i] === 1'b1) ne++;
    end
    n_vec++;
    if (ne != 1 || cap_v[1] !== 1'b0 || cap_b[2] !== 8'h50) begin
      n_err++;
      $display("FAIL unknown_shape got errs=%0d v1=%b b2=%h want 1 0 50", ne, cap_v[1], cap_b[2]);
    end
  endtask

  task automatic test_reset_mid();
    itch_msg_t mt, md;
    int        h;
    mt = rand_msg(4'd6);
    select(0);
    clear_exp();
    pend.push_back(mt);
    void'(place(0, mt, 0));
    run(11);
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL rst_pre cyc=%0d got v=%b b=%h d=%b want v=%b b=%h d=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], exp_v[i], exp_b[i], exp_d[i]);
      end
    end
    n_vec++;
    if (obs_valid !== 1'b1 || obs_byte !== exp_b[11]) begin
      n_err++; $display("FAIL rst_byte10 got v=%b b=%h want 1 %h", obs_valid, obs_byte, exp_b[11]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({obs_valid, obs_byte, obs_done, obs_ready} !== 11'h0) begin
      n_err++;
      $display("FAIL rst_async got v=%b b=%h d=%b r=%b want 0", obs_valid, obs_byte, obs_done, obs_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs_valid !== 1'b0 || obs_done !== 1'b0) begin
      n_err++; $display("FAIL rst_hold got v=%b d=%b want 0 0", obs_valid, obs_done);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (obs_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_release_ready got %b want 0", obs_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready_edge got %b want 1", obs_ready);
    end
    md = rand_msg(4'd3);
    clear_exp();
    pend.push_back(md);
    h = place(0, md, 0);
    run(h + 3);
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL rst_post cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_random(input int s, input int gap, input int nmsg);
    itch_msg_t m;
    int        h;
    select(s);
    clear_exp();
    h = 0;
    for (int k = 0; k < nmsg; k++) begin
      m = rand_msg(rand_type());
      pend.push_back(m);
      h = place(h, m, gap);
    end
    run(h + 2);
    for (int i = 0; i < cap_v.size(); i++) begin
      n_vec++;
      if (cap_v[i] !== exp_v[i] || cap_b[i] !== exp_b[i] || cap_d[i] !== exp_d[i] ||
          cap_e[i] !== exp_e[i] || cap_r[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL random_gap%0d cyc=%0d got v=%b b=%h d=%b e=%b r=%b want v=%b b=%h d=%b e=%b r=%b",
                 gap, i, cap_v[i], cap_b[i], cap_d[i], cap_e[i], cap_r[i],
                 exp_v[i], exp_b[i], exp_d[i], exp_e[i], exp_r[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delete();
    test_add();
    test_back_to_back();
    test_gap();
    test_unknown();
    test_reset_mid();
    for (int r = 0; r < 3; r++) begin
      test_random(0, 0, 8);
      test_random(1, 3, 7);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
